// File: rtl/sram_rw_if.sv
// Request, response and SRAM-port signals of the SRAM read/write controller.
// The controller uses the slave modport; the requester/SRAM side uses master.
`timescale 1ns/1ps
interface sram_rw_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24,
    parameter int MASK_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    logic              init_done;

    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata,
        input  resp_ready, sram_rdata,
        output req_ready, resp_valid, resp_rdata, init_done,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata,
        output resp_ready, sram_rdata,
        input  req_ready, resp_valid, resp_rdata, init_done,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );
endinterface

// File: rtl/sram_rw_ctrl.sv
// SRAM read/write controller: optional zero-fill after reset, then single-port
// masked writes and reads with a 2-entry in-order read response FIFO.
`timescale 1ns/1ps
module sram_rw_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 24,
    parameter int MASK_W  = 4,
    parameter bit INIT_EN = 1'b1
) (
    input  logic     clock,
    input  logic     reset,
    sram_rw_if.slave bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = INIT_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              push;
    logic              pop;
    logic              accept;
    logic [2:0]        credit;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        inflight_d = 1'b0;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        push = inflight_q;
        pop  = (count_q != 2'd0) && bus.resp_ready;

        // A pop this cycle frees its slot for a read accepted now; without it
        // back-to-back reads would stall every other cycle.
        credit = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

        bus.req_ready  = (state_q == ST_RUN) && !reset && (credit < 3'd2);
        accept         = bus.req_valid && bus.req_ready;

        bus.sram_en    = 1'b0;
        bus.sram_wmode = 1'b0;
        bus.sram_addr  = bus.req_addr;
        bus.sram_wmask = '0;
        bus.sram_wdata = '0;

        case (state_q)
            ST_INIT: begin
                bus.sram_en    = 1'b1;
                bus.sram_wmode = 1'b1;
                bus.sram_addr  = init_cnt_q;
                bus.sram_wmask = '1;
                bus.sram_wdata = '0;
                init_cnt_d     = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.sram_en = accept;
                if (accept) begin
                    bus.sram_wmode = bus.req_write;
                    bus.sram_wmask = bus.req_wmask;
                    bus.sram_wdata = bus.req_wdata;
                end
                inflight_d = accept && !bus.req_write;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = bus.sram_rdata;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        bus.resp_valid = (count_q != 2'd0);
        bus.resp_rdata = bus.resp_valid ? fifo_q[rd_ptr_q] : '0;
        bus.init_done  = (state_q == ST_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            init_cnt_q <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            // The credit check makes a push into a full FIFO unreachable.
            assert (!(push && (count_q == 2'd2)));
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl with a behavioural masked single-port SRAM.
`timescale 1ns/1ps
module tb_sram_rw_ctrl;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;
    localparam int MASK_W = 4;
    localparam int SEG_W  = DATA_W / MASK_W;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    sram_rw_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    sram_rw_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_EN(1'b1)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int s = 0; s < MASK_W; s++) begin
                    if (bus.sram_wmask[s]) mem[bus.sram_addr][s*SEG_W +: SEG_W] <= bus.sram_wdata[s*SEG_W +: SEG_W];
                end
            end else begin
                rdata_q <= mem[bus.sram_addr];
            end
        end
    end
    assign bus.sram_rdata = rdata_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wmask = m;
        bus.req_wdata = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.resp_ready = 1'b0;
        req(1'b0, 1'b0, '0, '0, '0);

        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_sram_en", bus.sram_en, 1);
        chk("rst_sram_addr", bus.sram_addr, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        cyc();
        rst = 1'b0;

        n = 0;
        bad = 0;
        for (int g = 0; g < 5000; g++) begin
            @(negedge clk);
            if (bus.init_done) break;
            if (!(bus.sram_en && bus.sram_wmode && bus.sram_wmask == 4'hF &&
                  bus.sram_wdata == 24'h0 && bus.sram_addr == n[ADDR_W-1:0])) bad++;
            n++;
            cyc();
        end
        chk("init_cycles", n, 4096);
        chk("init_bad_writes", bad, 0);
        chk("init_done", bus.init_done, 1);
        chk("run_req_ready", bus.req_ready, 1);
        cyc();

        bus.resp_ready = 1'b1;
        req(1'b1, 1'b0, 12'h123, 4'h0, 24'h0);
        @(negedge clk);
        chk("rd123_ready", bus.req_ready, 1);
        chk("rd123_sram_en", bus.sram_en, 1);
        chk("rd123_wmode", bus.sram_wmode, 0);
        cyc();
        req(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("rd123_lat1_valid", bus.resp_valid, 0);
        cyc();
        @(negedge clk);
        chk("rd123_lat2_valid", bus.resp_valid, 1);
        chk("rd123_data", bus.resp_rdata, 24'h000000);
        cyc();
        @(negedge clk);
        chk("rd123_drained", bus.resp_valid, 0);
        cyc();

        req(1'b0, 1'b1, 12'h055, 4'hF, 24'hFFFFFF);
        @(negedge clk);
        chk("idle_sram_en", bus.sram_en, 0);
        chk("idle_wmode", bus.sram_wmode, 0);
        chk("idle_wmask", bus.sram_wmask, 0);
        chk("idle_wdata", bus.sram_wdata, 0);
        cyc();

        req(1'b1, 1'b1, 12'h010, 4'hF, 24'hABCDEF);
        @(negedge clk);
        chk("wr010_en", bus.sram_en, 1);
        chk("wr010_wdata", bus.sram_wdata, 24'hABCDEF);
        cyc();
        req(1'b1, 1'b1, 12'h010, 4'h2, 24'h000000);
        @(negedge clk);
        chk("wr010_mask2_wmode", bus.sram_wmode, 1);
        chk("wr010_mask2_wmask", bus.sram_wmask, 4'h2);
        cyc();
        req(1'b1, 1'b0, 12'h010, 4'h0, 24'h0);
        @(negedge clk);
        cyc();
        req(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("rd010_lat1_valid", bus.resp_valid, 0);
        cyc();
        @(negedge clk);
        chk("rd010_lat2_valid", bus.resp_valid, 1);
        // mask bit 1 clears segment 1, bits 11:6 of 0xABCDEF
        chk("rd010_masked_data", bus.resp_rdata, 24'hABCDEF & ~24'h000FC0);
        cyc();

        for (int i = 0; i < 8; i++) begin
            req(1'b1, 1'b1, 12'(i), 4'hF, 24'h000100 + 24'(i));
            cyc();
        end
        req(1'b0, 1'b0, '0, '0, '0);
        cyc();

        bus.resp_ready = 1'b0;
        req(1'b1, 1'b0, 12'h001, 4'h0, 24'h0);
        @(negedge clk);
        chk("bp_rd1_ready", bus.req_ready, 1);
        cyc();
        req(1'b1, 1'b0, 12'h002, 4'h0, 24'h0);
        @(negedge clk);
        chk("bp_rd2_ready", bus.req_ready, 1);
        cyc();
        req(1'b1, 1'b0, 12'h003, 4'h0, 24'h0);
        @(negedge clk);
        chk("bp_rd3_blocked_a", bus.req_ready, 0);
        cyc();
        @(negedge clk);
        chk("bp_rd3_blocked_b", bus.req_ready, 0);
        chk("bp_head_valid", bus.resp_valid, 1);
        chk("bp_head_data", bus.resp_rdata, 24'h000101);
        cyc();
        @(negedge clk);
        chk("bp_rd3_blocked_c", bus.req_ready, 0);
        cyc();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_resp1_data", bus.resp_rdata, 24'h000101);
        chk("bp_rd3_accepted", bus.req_ready, 1);
        cyc();
        req(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("bp_resp2_valid", bus.resp_valid, 1);
        chk("bp_resp2_data", bus.resp_rdata, 24'h000102);
        cyc();
        @(negedge clk);
        chk("bp_resp3_valid", bus.resp_valid, 1);
        chk("bp_resp3_data", bus.resp_rdata, 24'h000103);
        cyc();
        @(negedge clk);
        chk("bp_drained", bus.resp_valid, 0);
        cyc();

        for (int c = 0; c < 12; c++) begin
            if (c < 8) req(1'b1, 1'b0, 12'(c), 4'h0, 24'h0);
            else       req(1'b0, 1'b0, '0, '0, '0);
            @(negedge clk);
            if (c < 8) chk($sformatf("b2b_ready_%0d", c), bus.req_ready, 1);
            if (c >= 2 && c < 10) begin
                chk($sformatf("b2b_valid_%0d", c), bus.resp_valid, 1);
                chk($sformatf("b2b_data_%0d", c), bus.resp_rdata, 24'h000100 + 24'(c - 2));
            end else begin
                chk($sformatf("b2b_idle_%0d", c), bus.resp_valid, 0);
            end
            cyc();
        end

        req(1'b1, 1'b1, 12'h020, 4'hF, 24'h13579B);
        @(negedge clk);
        cyc();
        req(1'b1, 1'b0, 12'h020, 4'h0, 24'h0);
        @(negedge clk);
        chk("raw020_ready", bus.req_ready, 1);
        cyc();
        req(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("raw020_valid", bus.resp_valid, 1);
        chk("raw020_data", bus.resp_rdata, 24'h13579B);
        cyc();

        req(1'b1, 1'b0, 12'h001, 4'h0, 24'h0);
        @(negedge clk);
        chk("rstrd_ready", bus.req_ready, 1);
        cyc();
        req(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstrd_resp_valid_a", bus.resp_valid, 0);
        chk("rstrd_req_ready", bus.req_ready, 0);
        chk("rstrd_init_done", bus.init_done, 0);
        chk("rstrd_sram_en", bus.sram_en, 1);
        chk("rstrd_sram_addr", bus.sram_addr, 0);
        cyc();
        @(negedge clk);
        chk("rstrd_resp_valid_b", bus.resp_valid, 0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("reinit_valid_%0d", k), bus.resp_valid, 0);
            chk($sformatf("reinit_addr_%0d", k), bus.sram_addr, 32'(k));
            chk($sformatf("reinit_rdata_%0d", k), bus.resp_rdata, 0);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
